// File: rtl/ahb_ram_slave.sv
// AHB-Lite responder over a single-port word RAM: writes take 1 data cycle, reads 2+WAIT_STATES (HREADYOUT low while waiting).
// Define AHB_RAM_ERR_EN to reject misaligned halfword/word transfers with the two-cycle ERROR response.
module ahb_ram_slave #(
  parameter int AW          = 15,
  parameter int WAIT_STATES = 0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int WW = AW - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD0,
    S_RWAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state_q, state_d, next_xfer;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   ram_q;
  logic [31:0]   hrdata_q;
  logic [31:0]   mem [2**WW];

  logic accept;
  logic size_byte;
  logic size_half;
  logic misaligned;
  logic rd_final;
  logic unused_ok;

  assign size_byte = (HSIZE == 3'b000);
  assign size_half = (HSIZE == 3'b001);
  assign accept    = HSEL & HTRANS[1] & HREADY & HREADYOUT;

  // Halfword lanes follow A[1] only, so a set A[0] is silently masked when not flagged as an error.
  always_comb begin
    mask_d = 4'b1111;
    if (size_byte) begin
      mask_d = 4'b0001 << HADDR[1:0];
    end else if (size_half) begin
      mask_d = HADDR[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef AHB_RAM_ERR_EN
  assign misaligned = (size_half & HADDR[0]) |
                      (~size_byte & ~size_half & (HADDR[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    next_xfer = S_IDLE;
    if (accept) begin
      if (misaligned) begin
        next_xfer = S_ERR1;
      end else if (HWRITE) begin
        next_xfer = S_WRITE;
      end else begin
        next_xfer = S_RD0;
      end
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RD0: begin
        state_d = S_RWAIT;
        cnt_d   = 3'(WAIT_STATES);
      end
      S_RWAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = next_xfer;
        end
      end
`ifdef AHB_RAM_ERR_EN
      S_ERR1:  state_d = S_ERR2;
`endif
      default: state_d = next_xfer;
    endcase
  end

  // Output logic; RWAIT with the counter at zero is the read completion cycle.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    rd_final  = 1'b0;
    case (state_q)
      S_RD0:   HREADYOUT = 1'b0;
      S_RWAIT: begin
        HREADYOUT = (cnt_q == 3'd0);
        rd_final  = (cnt_q == 3'd0);
      end
`ifdef AHB_RAM_ERR_EN
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      mask_q  <= 4'd0;
    end else if (accept) begin
      addr_q  <= HADDR[AW-1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
      mask_q  <= mask_d;
    end
  end

  // A reset clears state_q asynchronously, so an interrupted WRITE never reaches the RAM.
  always_ff @(posedge Clk) begin
    if (state_q == S_WRITE) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[addr_q[AW-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
    if (state_q == S_RD0) begin
      ram_q <= mem[addr_q[AW-1:2]];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hrdata_q <= 32'd0;
    end else if (rd_final) begin
      hrdata_q <= ram_q;
    end
  end

  assign HRDATA = rd_final ? ram_q : hrdata_q;

  assign unused_ok = ^{HMASTLOCK, HADDR[31:AW], HTRANS[0], write_q, size_q, addr_q[1:0]};

endmodule
